// File: rtl/qsys_rr_arbiter.sv
// ----------------------------------------------------------------------------
// qsys_rr_arbiter
//
// Round-robin arbiter that lets N_MASTERS Avalon-MM style masters share one
// pipelined slave. It accepts at most one read or write per cycle from the
// granted master and forwards it through registered slave command signals.
// The issuing master of each accepted transaction is recorded in a tag FIFO.
// The slave returns one readdatavalid per accepted command, in order, so the
// head of the FIFO always names the master that owns the current response.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   m_read/m_write    per-master command requests
//   m_writedata       packed per-master write data (master i at [i*WIDTH +: WIDTH])
//   m_address         packed per-master address (master i at [i*ADDR_WIDTH +: ADDR_WIDTH])
//   m_waitrequest     per-master stall (requesting but not granted)
//   m_readdata        response data, broadcast to every master
//   m_readdatavalid   one-hot response strobe to the owning master
//   s_read/s_write/s_writedata/s_address   registered command to the slave
//   s_readdata/s_readdatavalid             response from the slave
//   pending_count     number of outstanding transactions
//   err_unexpected    sticky flag: response arrived with no outstanding tag
// ----------------------------------------------------------------------------
module qsys_rr_arbiter #(
    parameter int N_MASTERS   = 4,
    parameter int WIDTH       = 32,
    parameter int ADDR_WIDTH  = 30,
    parameter int MAX_PENDING = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [N_MASTERS-1:0]             m_read,
    input  logic [N_MASTERS-1:0]             m_write,
    input  logic [N_MASTERS*WIDTH-1:0]       m_writedata,
    input  logic [N_MASTERS*ADDR_WIDTH-1:0]  m_address,
    output logic [N_MASTERS-1:0]             m_waitrequest,
    output logic [WIDTH-1:0]                 m_readdata,
    output logic [N_MASTERS-1:0]             m_readdatavalid,
    output logic                             s_read,
    output logic                             s_write,
    output logic [WIDTH-1:0]                 s_writedata,
    output logic [ADDR_WIDTH-1:0]            s_address,
    input  logic [WIDTH-1:0]                 s_readdata,
    input  logic                             s_readdatavalid,
    output logic [$clog2(MAX_PENDING+1)-1:0] pending_count,
    output logic                             err_unexpected
);

    localparam int TAG_W = $clog2(N_MASTERS);
    localparam int PTR_W = $clog2(MAX_PENDING);
    localparam int CNT_W = $clog2(MAX_PENDING+1);

    logic [N_MASTERS-1:0] request;
    logic [N_MASTERS-1:0] grant;
    logic                 granted;
    logic [TAG_W-1:0]     grant_idx;
    logic [TAG_W-1:0]     cand;
    logic [TAG_W-1:0]     last_grant;

    logic [TAG_W-1:0]     tag_mem [MAX_PENDING];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic                 full;
    logic                 empty;
    logic                 resp_valid;
    logic [TAG_W-1:0]     head_tag;

    assign request    = m_read | m_write;
    assign full       = (count == CNT_W'(MAX_PENDING));
    assign empty      = (count == '0);
    assign head_tag   = tag_mem[rd_ptr];
    assign resp_valid = s_readdatavalid & ~empty;

    // Search starts just after the last granted master so every requester
    // is reached within N_MASTERS accepts. A full FIFO blocks every grant,
    // even when a pop happens in the same cycle.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        granted   = 1'b0;
        cand      = '0;
        if (!full) begin
            for (int k = 1; k <= N_MASTERS; k++) begin
                cand = TAG_W'((int'(last_grant) + k) % N_MASTERS);
                if (!granted && request[cand]) begin
                    granted     = 1'b1;
                    grant[cand] = 1'b1;
                    grant_idx   = cand;
                end
            end
        end
    end

    assign m_waitrequest = rst ? '0 : (request & ~grant);

    // The response always belongs to the oldest outstanding tag.
    always_comb begin
        m_readdatavalid = '0;
        if (!rst && resp_valid) begin
            m_readdatavalid[head_tag] = 1'b1;
        end
    end

    assign m_readdata    = s_readdata;
    assign pending_count = count;

    // Tag storage carries no reset; only entries between the pointers are
    // ever read.
    always_ff @(posedge clk) begin
        if (!rst && granted) begin
            tag_mem[wr_ptr] <= grant_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_read         <= 1'b0;
            s_write        <= 1'b0;
            s_writedata    <= '0;
            s_address      <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            err_unexpected <= 1'b0;
            last_grant     <= TAG_W'(N_MASTERS-1);
        end else begin
            s_read  <= granted & m_read[grant_idx];
            s_write <= granted & m_write[grant_idx];
            if (granted) begin
                s_writedata <= m_writedata[grant_idx*WIDTH +: WIDTH];
                s_address   <= m_address[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
                last_grant  <= grant_idx;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (resp_valid) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({granted, resp_valid})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (s_readdatavalid && empty) begin
                err_unexpected <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_qsys_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_qsys_rr_arbiter
//
// Self-checking bench for qsys_rr_arbiter. A behavioural model (queue of
// owner tags, integer last-grant pointer, rotation search) predicts every
// output each cycle. A simple in-order slave model answers each command it
// sees on the slave port after a configurable latency. Directed scenarios are
// followed by a randomized phase with random requests, latencies, response
// stalls and occasional resets.
// ----------------------------------------------------------------------------
module tb_qsys_rr_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int AW = 30;
    localparam int MP = 4;
    localparam int CW = $clog2(MP+1);

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    m_read;
    logic [N-1:0]    m_write;
    logic [N*W-1:0]  m_writedata;
    logic [N*AW-1:0] m_address;
    logic [N-1:0]    m_waitrequest;
    logic [W-1:0]    m_readdata;
    logic [N-1:0]    m_readdatavalid;
    logic            s_read;
    logic            s_write;
    logic [W-1:0]    s_writedata;
    logic [AW-1:0]   s_address;
    logic [W-1:0]    s_readdata;
    logic            s_readdatavalid;
    logic [CW-1:0]   pending_count;
    logic            err_unexpected;

    always #5 clk = ~clk;

    qsys_rr_arbiter #(
        .N_MASTERS  (N),
        .WIDTH      (W),
        .ADDR_WIDTH (AW),
        .MAX_PENDING(MP)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .m_read          (m_read),
        .m_write         (m_write),
        .m_writedata     (m_writedata),
        .m_address       (m_address),
        .m_waitrequest   (m_waitrequest),
        .m_readdata      (m_readdata),
        .m_readdatavalid (m_readdatavalid),
        .s_read          (s_read),
        .s_write         (s_write),
        .s_writedata     (s_writedata),
        .s_address       (s_address),
        .s_readdata      (s_readdata),
        .s_readdatavalid (s_readdatavalid),
        .pending_count   (pending_count),
        .err_unexpected  (err_unexpected)
    );

    int total_checks  = 0;
    int passed_checks = 0;
    int failed_checks = 0;
    int cyc           = 0;

    // Reference model state
    int            q_tags[$];
    int            last_g;
    bit            exp_err;
    logic          exp_s_read;
    logic          exp_s_write;
    logic [W-1:0]  exp_s_wd;
    logic [AW-1:0] exp_s_addr;

    // Slave model state
    int            sl_due[$];
    logic [W-1:0]  sl_data[$];
    int            slave_lat   = 2;
    int            slave_allow = -1;
    bit            rand_lat    = 0;
    bit            rand_stall  = 0;
    bit            force_valid = 0;
    bit            use_next    = 0;
    logic [W-1:0]  next_resp;

    // Values sampled from the DUT mid-cycle by the last step
    logic [N-1:0]  obs_wait;
    logic [N-1:0]  obs_rdv;
    logic [W-1:0]  obs_rdata;
    int            obs_acc[N];

    task automatic checkOutput(string tag, logic [63:0] observed, logic [63:0] expected);
        total_checks++;
        assert (observed === expected) passed_checks++;
        else begin
            failed_checks++;
            $error("[TB] FAIL %s cyc=%0d observed=0x%0h expected=0x%0h", tag, cyc, observed, expected);
        end
    endtask

    function automatic logic [N-1:0] onehot(int idx);
        logic [N-1:0] r;
        r = '0;
        if (idx >= 0) r[idx] = 1'b1;
        return r;
    endfunction

    task automatic applyStimulus(int i, bit rd, bit wr, logic [AW-1:0] addr, logic [W-1:0] data);
        m_read[i]                = rd;
        m_write[i]               = wr;
        m_address[i*AW +: AW]    = addr;
        m_writedata[i*W +: W]    = data;
    endtask

    task automatic clearMasters();
        m_read  = '0;
        m_write = '0;
    endtask

    // One clock cycle: drive slave response, check every output against the
    // model mid-cycle, advance the model, then move to just after the edge.
    task automatic stepCycle();
        logic [N-1:0] req;
        logic [N-1:0] exp_wait;
        logic [N-1:0] exp_rdv;
        int           g;
        int           idx;
        int           due;
        bit           resp;
        resp = 1'b0;
        if (force_valid) begin
            s_readdatavalid = 1'b1;
            s_readdata      = $urandom;
            resp            = 1'b1;
        end else if (sl_due.size() > 0 && sl_due[0] <= cyc && slave_allow != 0 &&
                     !(rand_stall && $urandom_range(0, 3) == 0)) begin
            s_readdatavalid = 1'b1;
            s_readdata      = sl_data.pop_front();
            void'(sl_due.pop_front());
            resp            = 1'b1;
            if (slave_allow > 0) slave_allow--;
        end else begin
            s_readdatavalid = 1'b0;
            s_readdata      = $urandom;
        end

        #4;
        req = m_read | m_write;
        g   = -1;
        if (!rst && q_tags.size() < MP) begin
            for (int k = 1; k <= N; k++) begin
                idx = (last_g + k) % N;
                if (g < 0 && req[idx]) g = idx;
            end
        end
        exp_wait = rst ? '0 : (req & ~onehot(g));
        exp_rdv  = (!rst && resp && q_tags.size() > 0) ? onehot(q_tags[0]) : '0;

        obs_wait  = m_waitrequest;
        obs_rdv   = m_readdatavalid;
        obs_rdata = m_readdata;
        for (int i = 0; i < N; i++) begin
            if (!rst && req[i] && !obs_wait[i]) obs_acc[i]++;
        end

        checkOutput("waitrequest",   64'(obs_wait),       64'(exp_wait));
        checkOutput("readdatavalid", 64'(obs_rdv),        64'(exp_rdv));
        checkOutput("readdata",      64'(obs_rdata),      64'(s_readdata));
        checkOutput("s_read",        64'(s_read),         64'(exp_s_read));
        checkOutput("s_write",       64'(s_write),        64'(exp_s_write));
        checkOutput("s_writedata",   64'(s_writedata),    64'(exp_s_wd));
        checkOutput("s_address",     64'(s_address),      64'(exp_s_addr));
        checkOutput("pending_count", 64'(pending_count),  64'(q_tags.size()));
        checkOutput("err_unexpected",64'(err_unexpected), 64'(exp_err));

        // Slave sees the command currently on its port and schedules a reply.
        if (exp_s_read || exp_s_write) begin
            due = cyc + (rand_lat ? 1 + $urandom_range(0, 3) : slave_lat);
            if (sl_due.size() > 0 && due < sl_due[$]) due = sl_due[$];
            sl_due.push_back(due);
            sl_data.push_back(use_next ? next_resp : W'($urandom));
            use_next = 1'b0;
        end

        if (rst) begin
            q_tags.delete();
            last_g      = N - 1;
            exp_err     = 1'b0;
            exp_s_read  = 1'b0;
            exp_s_write = 1'b0;
            exp_s_wd    = '0;
            exp_s_addr  = '0;
        end else begin
            if (resp) begin
                if (q_tags.size() > 0) void'(q_tags.pop_front());
                else exp_err = 1'b1;
            end
            if (g >= 0) begin
                q_tags.push_back(g);
                last_g      = g;
                exp_s_read  = m_read[g];
                exp_s_write = m_write[g];
                exp_s_wd    = m_writedata[g*W +: W];
                exp_s_addr  = m_address[g*AW +: AW];
            end else begin
                exp_s_read  = 1'b0;
                exp_s_write = 1'b0;
            end
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic stepN(int n);
        for (int i = 0; i < n; i++) stepCycle();
    endtask

    initial begin
        rst             = 1'b1;
        m_read          = '0;
        m_write         = '0;
        m_writedata     = '0;
        m_address       = '0;
        s_readdata      = '0;
        s_readdatavalid = 1'b0;
        last_g          = N - 1;
        exp_err         = 1'b0;
        exp_s_read      = 1'b0;
        exp_s_write     = 1'b0;
        exp_s_wd        = '0;
        exp_s_addr      = '0;
        for (int i = 0; i < N; i++) obs_acc[i] = 0;
        @(posedge clk);
        #1;

        // Reset state
        stepN(2);
        rst = 1'b0;
        checkOutput("rst_pending", 64'(pending_count), 64'd0);
        checkOutput("rst_s_read",  64'(s_read),        64'd0);
        checkOutput("rst_err",     64'(err_unexpected), 64'd0);

        // Single read from master 0, fixed latency 2
        $display("[TB] single read");
        applyStimulus(0, 1'b1, 1'b0, 30'h10, 32'h0);
        use_next  = 1'b1;
        next_resp = 32'h0100_0005;
        stepCycle();
        clearMasters();
        checkOutput("t1_s_read",  64'(s_read),        64'd1);
        checkOutput("t1_s_addr",  64'(s_address),     64'h10);
        checkOutput("t1_pend1",   64'(pending_count), 64'd1);
        stepN(3);
        checkOutput("t1_rdv",     64'(obs_rdv),       64'b0001);
        checkOutput("t1_rdata",   64'(obs_rdata),     64'h0100_0005);
        checkOutput("t1_pend0",   64'(pending_count), 64'd0);

        // Fair rotation with all masters requesting continuously
        $display("[TB] continuous contention");
        for (int i = 0; i < N; i++) begin
            applyStimulus(i, 1'b1, 1'b0, AW'(32'h100 + i), W'(i));
            obs_acc[i] = 0;
        end
        stepCycle();
        checkOutput("t2_first_grant", 64'(obs_wait), 64'b1101);
        stepN(19);
        for (int i = 0; i < N; i++) checkOutput("t2_share", 64'(obs_acc[i]), 64'd5);
        clearMasters();
        stepN(6);
        checkOutput("t2_drained", 64'(pending_count), 64'd0);

        // Stalled slave: FIFO fills, one response frees exactly one slot
        $display("[TB] stalled slave");
        slave_allow = 0;
        for (int i = 0; i < N; i++) applyStimulus(i, 1'b1, 1'b0, AW'(32'h200 + i), W'(i));
        stepN(5);
        checkOutput("t3_full_pend", 64'(pending_count), 64'd4);
        checkOutput("t3_full_wait", 64'(obs_wait),      64'b1111);
        slave_allow = 1;
        stepCycle();
        checkOutput("t3_resp_owner", 64'(obs_rdv),  64'b0010);
        checkOutput("t3_still_full", 64'(obs_wait), 64'b1111);
        stepCycle();
        checkOutput("t3_next_grant", 64'(obs_wait),      64'b1101);
        checkOutput("t3_refilled",   64'(pending_count), 64'd4);
        clearMasters();
        slave_allow = -1;
        stepN(8);

        // Write from master 2
        $display("[TB] write routing");
        applyStimulus(2, 1'b0, 1'b1, 30'h44, 32'h0203_0007);
        stepCycle();
        clearMasters();
        checkOutput("t4_s_write", 64'(s_write),     64'd1);
        checkOutput("t4_s_read",  64'(s_read),      64'd0);
        checkOutput("t4_s_wd",    64'(s_writedata), 64'h0203_0007);
        stepN(3);
        checkOutput("t4_rdv",     64'(obs_rdv),     64'b0100);

        // Spurious response with nothing outstanding
        $display("[TB] unexpected response");
        force_valid = 1'b1;
        stepCycle();
        force_valid = 1'b0;
        checkOutput("t5_no_rdv", 64'(obs_rdv),        64'd0);
        checkOutput("t5_err",    64'(err_unexpected), 64'd1);
        stepN(3);
        checkOutput("t5_sticky", 64'(err_unexpected), 64'd1);

        // Reset with three outstanding transactions
        $display("[TB] reset mid-transfer");
        slave_allow = 0;
        applyStimulus(0, 1'b1, 1'b0, 30'h300, 32'h0);
        stepN(3);
        checkOutput("t6_pend3", 64'(pending_count), 64'd3);
        rst = 1'b1;
        stepCycle();
        checkOutput("t6_rst_wait", 64'(obs_wait), 64'd0);
        rst = 1'b0;
        clearMasters();
        checkOutput("t6_pend0",   64'(pending_count),  64'd0);
        checkOutput("t6_s_read",  64'(s_read),         64'd0);
        checkOutput("t6_err_clr", 64'(err_unexpected), 64'd0);
        slave_allow = -1;
        applyStimulus(0, 1'b1, 1'b0, 30'h310, 32'h0);
        applyStimulus(3, 1'b1, 1'b0, 30'h313, 32'h0);
        stepCycle();
        checkOutput("t6_m0_wins", 64'(obs_wait), 64'b1000);
        clearMasters();
        stepN(3);
        checkOutput("t6_late_err", 64'(err_unexpected), 64'd1);
        stepN(6);

        // Randomized traffic against the model
        $display("[TB] random traffic");
        rand_lat   = 1'b1;
        rand_stall = 1'b1;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N; i++) begin
                applyStimulus(i, ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                              AW'($urandom), W'($urandom));
            end
            rst = ($urandom_range(0, 63) == 0);
            stepCycle();
        end
        rst = 1'b0;
        clearMasters();
        stepN(10);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule

// File: doc/qsys_rr_arbiter.md
Name: qsys_rr_arbiter

Overview:
Round-robin arbiter that shares a single qsys_slave-style Avalon-MM slave between N_MASTERS requesters in the Qsys perf-eval designs. It accepts one read or write per cycle from the granted master and drives registered slave command signals. It records the issuing master of each transaction in a tag FIFO and routes each returned readdatavalid to that master. The slave returns exactly one readdatavalid per accepted read or write, in order.

Parameters:
N_MASTERS, 4, number of requesting masters (2..16)
WIDTH, 32, data width of writedata/readdata
ADDR_WIDTH, 30, address width
MAX_PENDING, 4, max outstanding transactions; depth of the tag FIFO (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
m_read  in  N_MASTERS  per-master read request
m_write  in  N_MASTERS  per-master write request
m_writedata  in  N_MASTERS*WIDTH  packed, master i at [i*WIDTH +: WIDTH]
m_address  in  N_MASTERS*ADDR_WIDTH  packed, master i at [i*ADDR_WIDTH +: ADDR_WIDTH]
m_waitrequest  out  N_MASTERS  per-master stall
m_readdata  out  WIDTH  response data, broadcast to all masters
m_readdatavalid  out  N_MASTERS  one-hot response strobe
s_read  out  1  to slave
s_write  out  1  to slave
s_writedata  out  WIDTH  to slave
s_address  out  ADDR_WIDTH  to slave
s_readdata  in  WIDTH  from slave
s_readdatavalid  in  1  from slave
pending_count  out  $clog2(MAX_PENDING+1)  outstanding transactions
err_unexpected  out  1  sticky: response arrived with empty tag FIFO

Behaviour:
- Master i requests when m_read[i]|m_write[i]. Read and write both high = one transaction; both flags are forwarded as-is.
- Grant (combinational): if pending_count < MAX_PENDING, grant the first requester in order last_grant+1, last_grant+2, ... (mod N_MASTERS). Otherwise grant none. A pop in the same cycle does not free a slot (conservative; full means no grant).
- m_waitrequest[i] = request_i & ~grant_i. A master that is not requesting sees 0.
- Accept = request & grant. On accept at cycle T:
  - last_grant <= i.
  - Push tag i into the FIFO.
  - s_read/s_write/s_writedata/s_address <= master i's values, visible in cycle T+1.
- When no accept occurs: s_read=s_write=0 next cycle; s_writedata/s_address hold their last values.
- Response: when s_readdatavalid=1 and the FIFO is non-empty:
  - m_readdatavalid[head]=1 in the same cycle (combinational).
  - m_readdata = s_readdata (always passed through combinationally).
  - Pop the FIFO.
- If s_readdatavalid=1 with the FIFO empty: no m_readdatavalid, no pop, err_unexpected <= 1 (sticky until rst).
- pending_count = FIFO occupancy: +1 on push, -1 on pop, unchanged on simultaneous push and pop. Never exceeds MAX_PENDING.
- FIFO read/write pointers wrap modulo MAX_PENDING.
- Latency with qsys_slave: accept at T -> s_read/s_write high at T+1 -> m_readdatavalid at T+3.
- Reset (any cycle, including mid-transfer):
  - s_read=s_write=0, s_writedata=0, s_address=0.
  - FIFO flushed, pending_count=0, err_unexpected=0.
  - last_grant=N_MASTERS-1, so master 0 has first priority.
  - m_waitrequest and m_readdatavalid are forced to 0 while rst=1.
  - Responses arriving after reset for pre-reset transactions set err_unexpected (intended).

Test Plan:
1. Single master 0 reads addr 0x10, slave returns 0x0100_0005 -> s_read high at T+1, m_readdatavalid=4'b0001 at T+3 with m_readdata=0x0100_0005, pending_count 1 then 0.
2. All 4 masters request continuously, MAX_PENDING=4, slave latency 2 -> grants cycle 0,1,2,3,0,1..., each master gets 25% of accepts, and responses reach masters in issue order.
3. Slave stalls responses (readdatavalid held 0) -> exactly 4 accepts, then all m_waitrequest=1 and pending_count=4. One response -> pending 3, and one new grant goes to the next master in rotation.
4. Master 2 has write=1, writedata=0x0203_0007 -> s_write=1, s_writedata=0x0203_0007 next cycle; the write response is routed only to m_readdatavalid[2].
5. s_readdatavalid pulsed with no outstanding transaction -> no m_readdatavalid bit set, err_unexpected=1 and held; cleared only by rst.
6. rst asserted with 3 outstanding -> pending_count=0, s_read=0 next cycle. Post-reset late response sets err_unexpected, and master 0 wins the first post-reset contention with master 3.
